// File: rtl/grp_enable_scatter_pkg.sv
// Shared types and constants for the group enable scatter path.
// Grid geometry, event record layout and the grant priority encoder.
package grp_enable_scatter_pkg;

  localparam int unsigned GRP_ROWS       = 4;
  localparam int unsigned GRP_COLS       = 4;
  localparam int unsigned NUM_GROUPS     = GRP_ROWS * GRP_COLS;
  localparam int unsigned GRP_ADD        = 2;
  localparam int unsigned PIX_ADD        = 2;
  localparam int unsigned GRP_IDX_W      = $clog2(NUM_GROUPS);
  localparam int unsigned TIMEOUT_CYCLES = 255;
  localparam int unsigned WD_W           = 8;

  typedef enum logic {
    IDLE,
    ACTIVE
  } state_t;

  typedef struct packed {
    logic [GRP_ADD-1:0] grp_y;
    logic [GRP_ADD-1:0] grp_x;
    logic [PIX_ADD-1:0] pix_y;
    logic [PIX_ADD-1:0] pix_x;
  } evt_t;

  // Lowest set bit wins; an empty vector maps to group 0.
  function automatic logic [GRP_IDX_W-1:0] grp_index(input logic [NUM_GROUPS-1:0] vec);
    logic [GRP_IDX_W-1:0] idx;
    idx = '0;
    for (int unsigned i = NUM_GROUPS; i > 0; i--) begin
      if (vec[i-1]) idx = GRP_IDX_W'(i - 1);
    end
    return idx;
  endfunction

endpackage

// File: rtl/grp_enable_scatter_evt_out_reg.sv
// Single-entry valid/ready holding register for packed pixel events.
// Accepts a new event in the same cycle the held one is popped.
module evt_out_reg
  import grp_enable_scatter_pkg::*;
(
  input  logic clk_i,
  input  logic reset_i,
  input  logic in_valid_i,
  output logic in_ready_o,
  input  evt_t in_data_i,
  output logic out_valid_o,
  input  logic out_ready_i,
  output evt_t out_data_o
);

  assign in_ready_o = !out_valid_o || out_ready_i;

  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      out_valid_o <= 1'b0;
      out_data_o  <= '0;
    end else if (in_valid_i && in_ready_o) begin
      out_valid_o <= 1'b1;
      out_data_o  <= in_data_i;
    end else if (out_ready_i) begin
      out_valid_o <= 1'b0;
    end
  end

endmodule

// File: rtl/grp_enable_scatter.sv
// Turns a level-1 group grant into a one-hot group enable, packs the granted
// group's pixel events into an output register and ends on release or watchdog.
module grp_enable_scatter
  import grp_enable_scatter_pkg::*;
#(
  parameter int unsigned TIMEOUT = TIMEOUT_CYCLES
) (
  input  logic                                clk_i,
  input  logic                                reset_i,
  input  logic                                gnt_valid_i,
  input  logic [NUM_GROUPS-1:0]               gnt_i,
  output logic                                gnt_ack_o,
  output logic [GRP_ROWS-1:0][GRP_COLS-1:0]   enable_o,
  input  logic                                pix_valid_i,
  input  logic [PIX_ADD-1:0]                  pix_x_i,
  input  logic [PIX_ADD-1:0]                  pix_y_i,
  output logic                                pix_ready_o,
  input  logic                                grp_release_i,
  output logic                                evt_valid_o,
  input  logic                                evt_ready_i,
  output logic [GRP_ADD-1:0]                  evt_grp_x_o,
  output logic [GRP_ADD-1:0]                  evt_grp_y_o,
  output logic [PIX_ADD-1:0]                  evt_pix_x_o,
  output logic [PIX_ADD-1:0]                  evt_pix_y_o,
  output logic                                timeout_o
);

  state_t                state_q;
  logic [GRP_IDX_W-1:0]  grp_q;
  logic [NUM_GROUPS-1:0] en_q;
  logic                  ack_q;
  logic                  timeout_q;
  logic [WD_W-1:0]       wd_cnt_q;

  logic active;
  logic evt_in_ready;
  logic push;
  logic wd_fire;
  logic release_now;
  evt_t evt_in;
  evt_t evt_out;

  assign active      = (state_q == ACTIVE);
  assign pix_ready_o = active && evt_in_ready;
  assign push        = pix_valid_i && pix_ready_o;
  assign wd_fire     = active && (wd_cnt_q == WD_W'(TIMEOUT));
  assign release_now = active && (grp_release_i || wd_fire);

  always_comb begin
    evt_in       = '0;
    evt_in.grp_y = GRP_ADD'(32'(grp_q) / GRP_COLS);
    evt_in.grp_x = GRP_ADD'(32'(grp_q) % GRP_COLS);
    evt_in.pix_y = pix_y_i;
    evt_in.pix_x = pix_x_i;
  end

  evt_out_reg u_evt_out (
    .clk_i       (clk_i),
    .reset_i     (reset_i),
    .in_valid_i  (push),
    .in_ready_o  (evt_in_ready),
    .in_data_i   (evt_in),
    .out_valid_o (evt_valid_o),
    .out_ready_i (evt_ready_i),
    .out_data_o  (evt_out)
  );

  // Grants are held off during the ack cycle so a still-asserted old grant is not re-taken.
  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      state_q   <= IDLE;
      grp_q     <= '0;
      en_q      <= '0;
      ack_q     <= 1'b0;
      wd_cnt_q  <= '0;
      timeout_q <= 1'b0;
    end else begin
      ack_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (gnt_valid_i && (|gnt_i) && !ack_q) begin
            grp_q    <= grp_index(gnt_i);
            en_q     <= NUM_GROUPS'(1) << grp_index(gnt_i);
            wd_cnt_q <= '0;
            state_q  <= ACTIVE;
          end
        end
        ACTIVE: begin
          if (release_now) begin
            en_q     <= '0;
            ack_q    <= 1'b1;
            wd_cnt_q <= '0;
            state_q  <= IDLE;
            if (wd_fire) timeout_q <= 1'b1;
          end else if (push) begin
            wd_cnt_q <= '0;
          end else if (!pix_valid_i) begin
            wd_cnt_q <= wd_cnt_q + WD_W'(1);
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign enable_o    = en_q;
  assign gnt_ack_o   = ack_q;
  assign timeout_o   = timeout_q;
  assign evt_grp_x_o = evt_out.grp_x;
  assign evt_grp_y_o = evt_out.grp_y;
  assign evt_pix_x_o = evt_out.pix_x;
  assign evt_pix_y_o = evt_out.pix_y;

endmodule
